// File: rtl/apb_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_ctrl
// Brief    : APB requester with a valid/ready command port, wait-state
//            support and a programmable pready watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_ctrl #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Counter is sized to hold TIMEOUT-1, the last wait cycle before abort.
    localparam int              CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int              LIMIT    = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(LIMIT);
    localparam bit              WD_EN    = (TIMEOUT != 0);

    state_t           state;
    logic [CNT_W-1:0] wd_cnt;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state       <= IDLE;
            wd_cnt      <= '0;
            cmd_ready   <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        paddr     <= cmd_addr;
                        pwrite    <= cmd_write;
                        pwdata    <= cmd_wdata;
                        psel      <= 1'b1;
                        cmd_ready <= 1'b0;
                        wd_cnt    <= '0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // A ready response wins over a watchdog expiry in the same cycle.
                    if (pready) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        cmd_ready   <= 1'b1;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= pwrite ? '0 : prdata;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        state       <= IDLE;
                    end else if (WD_EN && (wd_cnt == WD_LIMIT)) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        cmd_ready   <= 1'b1;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        state       <= IDLE;
                    end else if (WD_EN) begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    psel      <= 1'b0;
                    penable   <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_ctrl.sv
`default_nettype none
// Directed self-checking bench for apb_master_ctrl (TIMEOUT = 16).
module tb_apb_master_ctrl;

    logic       pclk = 1'b0;
    logic       presetn;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid, rsp_err, rsp_timeout;
    logic [7:0] rsp_rdata;
    logic [3:0] paddr;
    logic       psel, penable, pwrite;
    logic [7:0] pwdata, prdata;
    logic       pready, pslverr;

    int compared = 0;
    int mismatched = 0;
    int lat, en_cyc, setups, rsps;
    logic stable;

    apb_master_ctrl #(.ADDR_W(4), .DATA_W(8), .TIMEOUT(16)) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one command, inserts `waits` wait states, returns cycles from
    // acceptance to rsp_valid and the number of cycles penable was high.
    task automatic run(input logic wr, input logic [3:0] a, input logic [7:0] d,
                       input int waits, input logic [7:0] rd, input logic err,
                       output int latency, output int enables, output logic stab);
        int acc;
        acc = 0; latency = 0; enables = 0; stab = 1'b1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        pready = 1'b0; pslverr = 1'b0; prdata = 8'h00;
        tick();
        cmd_valid = 1'b0; latency = 1;
        while (!rsp_valid && latency < 40) begin
            if (psel && (paddr !== a || pwrite !== wr || pwdata !== d)) stab = 1'b0;
            if (penable) begin
                enables++;
                if (acc >= waits) begin
                    pready = 1'b1; prdata = rd; pslverr = err;
                end else begin
                    pready = 1'b0;
                end
                acc++;
            end
            tick();
            latency++;
        end
        pready = 1'b0; pslverr = 1'b0; prdata = 8'h00;
    endtask

    initial begin
        presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
        tick(); tick();
        chk("rst_psel", {31'b0, psel}, 32'd0);
        chk("rst_penable", {31'b0, penable}, 32'd0);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_paddr_pwdata", {20'b0, paddr, pwdata}, 32'd0);
        presetn = 1'b1;
        tick();

        // 1: zero-wait write, cycle-by-cycle
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h3; cmd_wdata = 8'hA5; pready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("w_c1_setup", {28'b0, psel, penable, pwrite, cmd_ready}, 32'b1010);
        chk("w_c1_bus", {20'b0, paddr, pwdata}, {20'b0, 4'h3, 8'hA5});
        tick();
        chk("w_c2_access", {30'b0, psel, penable}, 32'b11);
        tick();
        chk("w_c3_rsp", {27'b0, rsp_valid, rsp_err, rsp_timeout, psel, cmd_ready}, 32'b10001);
        chk("w_c3_rdata", {24'b0, rsp_rdata}, 32'h00);
        pready = 1'b0;
        tick();
        chk("w_c4_pulse", {31'b0, rsp_valid}, 32'd0);

        // 2: read with 3 wait states
        run(1'b0, 4'h3, 8'h11, 3, 8'hA5, 1'b0, lat, en_cyc, stable);
        chk("r_latency", lat, 32'd6);
        chk("r_penable_cycles", en_cyc, 32'd4);
        chk("r_rdata_err", {23'b0, rsp_rdata, rsp_err}, {23'b0, 8'hA5, 1'b0});
        chk("r_bus_stable", {31'b0, stable}, 32'd1);
        chk("r_idle_bus", {30'b0, psel, penable}, 32'd0);
        tick();

        // 3: read with pslverr
        run(1'b0, 4'h9, 8'h00, 0, 8'hC3, 1'b1, lat, en_cyc, stable);
        chk("e_latency", lat, 32'd3);
        chk("e_flags", {30'b0, rsp_err, rsp_timeout}, 32'b10);
        chk("e_rdata", {24'b0, rsp_rdata}, 32'hC3);
        tick();

        // 4: responder never ready -> watchdog abort
        run(1'b1, 4'hE, 8'h5A, 100, 8'hFF, 1'b0, lat, en_cyc, stable);
        chk("t_latency", lat, 32'd18);
        chk("t_penable_cycles", en_cyc, 32'd16);
        chk("t_flags", {29'b0, rsp_valid, rsp_err, rsp_timeout}, 32'b111);
        chk("t_rdata", {24'b0, rsp_rdata}, 32'h00);
        chk("t_bus_dropped", {29'b0, psel, penable, cmd_ready}, 32'b001);
        tick();
        chk("t_hold", {29'b0, rsp_valid, rsp_err, rsp_timeout}, 32'b011);

        // 5: back-to-back write then read, cmd_valid held high
        setups = 0; rsps = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h5; cmd_wdata = 8'h3C;
        pready = 1'b1; prdata = 8'h5A;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (psel && !penable) setups++;
            if (rsp_valid) rsps++;
            if (c == 3) begin
                chk("b_first_rsp", {30'b0, rsp_valid, cmd_ready}, 32'b11);
                cmd_write = 1'b0; cmd_addr = 4'h6;
            end
            if (c == 4) begin
                chk("b_second_setup", {25'b0, psel, penable, pwrite, paddr}, {25'b0, 3'b100, 4'h6});
                cmd_valid = 1'b0;
            end
            if (c == 6) chk("b_second_rsp", {23'b0, rsp_valid, rsp_rdata}, {23'b0, 1'b1, 8'h5A});
        end
        chk("b_setup_count", setups, 32'd2);
        chk("b_rsp_count", rsps, 32'd2);
        pready = 1'b0; prdata = 8'h00;

        // 6: asynchronous reset during ACCESS
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h2;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("ar_in_access", {30'b0, psel, penable}, 32'b11);
        #2 presetn = 1'b0;
        #1;
        chk("ar_bus_dropped", {29'b0, psel, penable, rsp_valid}, 32'd0);
        chk("ar_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        tick();
        presetn = 1'b1;
        rsps = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (rsp_valid) rsps++;
        end
        chk("ar_no_rsp", rsps, 32'd0);
        run(1'b1, 4'h7, 8'h81, 0, 8'h00, 1'b0, lat, en_cyc, stable);
        chk("ar_next_latency", lat, 32'd3);
        chk("ar_next_flags", {30'b0, rsp_err, rsp_timeout}, 32'b00);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
